// File: rtl/cpu_pkg.sv
// Shared encodings for the accumulator CPU control unit: opcodes, FSM states,
// ALU select values and skip-condition codes.
package cpu_pkg;

   typedef enum logic [3:0] {
      OP_NOP0   = 4'h0,
      OP_LOAD   = 4'h1,
      OP_STORE  = 4'h2,
      OP_CLEAR  = 4'h3,
      OP_SKIP   = 4'h4,
      OP_JUMP   = 4'h5,
      OP_HALT   = 4'h6,
      OP_ADD    = 4'h7,
      OP_SUB    = 4'h8,
      OP_AND    = 4'h9,
      OP_OR     = 4'hA,
      OP_NOT    = 4'hB,
      OP_LOADI  = 4'hC,
      OP_STOREI = 4'hD,
      OP_ADDI   = 4'hE,
      OP_NOPF   = 4'hF
   } opcode_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_PTRREAD,
      S_OPREAD,
      S_EXEC,
      S_WRITE,
      S_HALT
   } state_t;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_NOT = 3'b100;

   localparam logic [1:0] SKIP_NEG   = 2'b00;
   localparam logic [1:0] SKIP_ZERO  = 2'b01;
   localparam logic [1:0] SKIP_POS   = 2'b10;
   localparam logic [1:0] SKIP_NEVER = 2'b11;

endpackage

// File: rtl/acc_cpu_controller.sv
// Moore-FSM control unit for the 16-bit accumulator CPU: owns PC/IR/MBR/AC/EA,
// sequences fetch/decode/execute over the shared memory port and drives the ALU.
module acc_cpu_controller
   import cpu_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH = 12,
   parameter int unsigned           DATA_WIDTH = 16,
   parameter logic [ADDR_WIDTH-1:0] PC_RESET   = 'h100
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  run,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_cs,
   output logic                  mem_oe,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ready,
   output logic [DATA_WIDTH-1:0] alu_a,
   output logic [DATA_WIDTH-1:0] alu_b,
   output logic [2:0]            alu_sel,
   input  logic [DATA_WIDTH-1:0] alu_out,
   output logic                  halted,
   output logic [ADDR_WIDTH-1:0] pc_o,
   output logic [DATA_WIDTH-1:0] ac_o
);

   localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(2);

   state_t                  state, next_state;
   opcode_t                 op;
   logic [ADDR_WIDTH-1:0]   pc, ea;
   logic [DATA_WIDTH-1:0]   ir, mbr, ac;
   logic                    skip_taken;

   assign op = opcode_t'(ir[DATA_WIDTH-1 -: 4]);

   always_comb begin
      skip_taken = 1'b0;
      case (ir[1:0])
         SKIP_NEG:   skip_taken = ac[DATA_WIDTH-1];
         SKIP_ZERO:  skip_taken = (ac == '0);
         SKIP_POS:   skip_taken = !ac[DATA_WIDTH-1] && (ac != '0);
         SKIP_NEVER: skip_taken = 1'b0;
         default:    skip_taken = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:   if (run) next_state = S_FETCH;
         S_FETCH:  if (mem_ready) next_state = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR: next_state = S_OPREAD;
               OP_STORE:                               next_state = S_WRITE;
               OP_LOADI, OP_STOREI, OP_ADDI:           next_state = S_PTRREAD;
               OP_HALT:                                next_state = S_HALT;
               OP_NOT:                                 next_state = S_EXEC;
               default:                                next_state = S_FETCH;
            endcase
         end
         S_PTRREAD: if (mem_ready) next_state = (op == OP_STOREI) ? S_WRITE : S_OPREAD;
         S_OPREAD:  if (mem_ready) next_state = S_EXEC;
         S_EXEC:    next_state = S_FETCH;
         S_WRITE:   if (mem_ready) next_state = S_FETCH;
         S_HALT:    next_state = S_HALT;
         default:   next_state = S_IDLE;
      endcase
   end

   always_comb begin
      mem_oe   = (state == S_FETCH) || (state == S_PTRREAD) || (state == S_OPREAD);
      mem_we   = (state == S_WRITE);
      mem_cs   = mem_oe || mem_we;
      mem_addr = (state == S_FETCH) ? pc : ea;
      halted   = (state == S_HALT);
      case (op)
         OP_SUB:  alu_sel = ALU_SUB;
         OP_AND:  alu_sel = ALU_AND;
         OP_OR:   alu_sel = ALU_OR;
         OP_NOT:  alu_sel = ALU_NOT;
         default: alu_sel = ALU_ADD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc  <= PC_RESET;
         ac  <= '0;
         ir  <= '0;
         mbr <= '0;
         ea  <= '0;
      end else begin
         case (state)
            S_FETCH: if (mem_ready) begin
               ir <= mem_rdata;
               pc <= pc + PC_STEP;
               ea <= mem_rdata[ADDR_WIDTH-1:0];
            end
            S_DECODE: begin
               case (op)
                  OP_CLEAR: ac <= '0;
                  OP_SKIP:  if (skip_taken) pc <= pc + PC_STEP;
                  OP_JUMP:  pc <= ir[ADDR_WIDTH-1:0];
                  default:  ;
               endcase
            end
            S_PTRREAD: if (mem_ready) ea <= mem_rdata[ADDR_WIDTH-1:0];
            S_OPREAD:  if (mem_ready) mbr <= mem_rdata;
            S_EXEC:    ac <= (op == OP_LOAD || op == OP_LOADI) ? mbr : alu_out;
            default:   ;
         endcase
      end
   end

   assign mem_wdata = ac;
   assign alu_a     = ac;
   assign alu_b     = (op == OP_NOT) ? '0 : mbr;
   assign pc_o      = pc;
   assign ac_o      = ac;

endmodule

// File: tb/tb_acc_cpu_controller.sv
// Bench for acc_cpu_controller: behavioural ALU and wait-state memory, write
// scoreboard, and per-feature program scenarios.
module tb_acc_cpu_controller;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        run = 1'b0;
   logic [11:0] mem_addr;
   logic        mem_cs, mem_oe, mem_we;
   logic [15:0] mem_wdata, mem_rdata;
   logic        mem_ready;
   logic [15:0] alu_a, alu_b, alu_out;
   logic [2:0]  alu_sel;
   logic        halted;
   logic [11:0] pc_o;
   logic [15:0] ac_o;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [11:0] a;
      logic [15:0] d;
   } wr_t;
   wr_t sb_q[$];

   logic [15:0] mem [0:4095];
   int          wait_states = 0;
   int          wait_cnt = 0;
   logic        hold_ready = 1'b0;
   logic        pl_en = 1'b0;
   logic [11:0] pl_addr = '0;
   logic [15:0] pl_data = '0;

   logic        prev_pending = 1'b0;
   logic        prev_rst = 1'b1;
   logic [13:0] prev_sig = '0;

   always #5 clk = ~clk;

   acc_cpu_controller #(.ADDR_WIDTH(12), .DATA_WIDTH(16), .PC_RESET(12'h100)) dut (
      .clk(clk), .rst(rst), .run(run),
      .mem_addr(mem_addr), .mem_cs(mem_cs), .mem_oe(mem_oe), .mem_we(mem_we),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
      .halted(halted), .pc_o(pc_o), .ac_o(ac_o)
   );

   always_comb begin
      case (alu_sel)
         3'b000:  alu_out = alu_a + alu_b;
         3'b001:  alu_out = alu_a - alu_b;
         3'b010:  alu_out = alu_a & alu_b;
         3'b011:  alu_out = alu_a | alu_b;
         3'b100:  alu_out = ~alu_a;
         default: alu_out = '0;
      endcase
   end

   assign mem_rdata = mem[mem_addr];
   assign mem_ready = mem_cs && !hold_ready && (wait_cnt >= wait_states);

   always @(posedge clk) begin
      if (pl_en) mem[pl_addr] <= pl_data;
      if (mem_cs && mem_we && mem_ready && !rst) mem[mem_addr] <= mem_wdata;
      if (rst || !mem_cs || mem_ready) wait_cnt <= 0;
      else                             wait_cnt <= wait_cnt + 1;
   end

   // Write scoreboard and strobe-stability monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (prev_pending && !prev_rst) begin
         checks++;
         if ({mem_addr, mem_oe, mem_we} !== prev_sig) begin
            errors++;
            $display("FAIL stable_wait got %h required %h", {mem_addr, mem_oe, mem_we}, prev_sig);
         end
      end
      prev_pending = mem_cs && !mem_ready;
      prev_rst     = rst;
      prev_sig     = {mem_addr, mem_oe, mem_we};
      if (mem_cs && mem_we && mem_ready && !rst) begin
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write addr=%h data=%h required none", mem_addr, mem_wdata);
         end else begin
            wr_t e;
            e = sb_q.pop_front();
            if ({mem_addr, mem_wdata} !== {e.a, e.d}) begin
               errors++;
               $display("FAIL write addr/data got %h/%h required %h/%h", mem_addr, mem_wdata, e.a, e.d);
            end
         end
      end
   end

   task automatic poke(input logic [11:0] a, input logic [15:0] d);
      @(negedge clk);
      pl_addr = a;
      pl_data = d;
      pl_en   = 1'b1;
      @(negedge clk);
      pl_en   = 1'b0;
   endtask

   task automatic expect_write(input logic [11:0] a, input logic [15:0] d);
      wr_t e;
      e.a = a;
      e.d = d;
      sb_q.push_back(e);
   endtask

   // Returns with run already sampled (DUT in FETCH).
   task automatic start_cpu();
      @(negedge clk);
      rst = 1'b1;
      run = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run = 1'b1;
      @(negedge clk);
      run = 1'b0;
   endtask

   task automatic run_to_halt(input int budget, output int edges);
      edges = -1;
      for (int n = 1; n <= budget; n++) begin
         @(negedge clk);
         if (halted) begin
            edges = n;
            break;
         end
      end
   endtask

   task automatic test_reset();
      poke(12'h100, 16'h6000);
      @(negedge clk);
      rst = 1'b1;
      run = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({pc_o, ac_o} !== {12'h100, 16'h0000}) begin
         errors++;
         $display("FAIL reset_regs pc/ac got %h/%h required 100/0000", pc_o, ac_o);
      end
      checks++;
      if ({mem_cs, mem_oe, mem_we, halted, alu_sel} !== 7'b0) begin
         errors++;
         $display("FAIL reset_outs cs,oe,we,halted,sel got %b required 0000000",
                  {mem_cs, mem_oe, mem_we, halted, alu_sel});
      end
      run = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (mem_cs !== 1'b0) begin
         errors++;
         $display("FAIL idle_no_run cs got %b required 0", mem_cs);
      end
      run = 1'b1;
      @(negedge clk);
      run = 1'b0;
      checks++;
      if ({mem_oe, mem_we, mem_addr} !== {2'b10, 12'h100}) begin
         errors++;
         $display("FAIL first_fetch oe,we,addr got %b,%b,%h required 1,0,100", mem_oe, mem_we, mem_addr);
      end
   endtask

   task automatic test_load_add_store(input int ws, input int exp_edges);
      int edges;
      wait_states = ws;
      poke(12'h11A, 16'h0001);
      poke(12'h11C, 16'h0002);
      poke(12'h11E, 16'h0000);
      poke(12'h100, 16'h111C);
      poke(12'h102, 16'h711A);
      poke(12'h104, 16'h211E);
      poke(12'h106, 16'h6000);
      expect_write(12'h11E, 16'h0003);
      start_cpu();
      run_to_halt(200, edges);
      checks++;
      if (edges !== exp_edges) begin
         errors++;
         $display("FAIL las_latency ws=%0d edges got %0d required %0d", ws, edges, exp_edges);
      end
      checks++;
      if ({pc_o, ac_o, mem[12'h11E]} !== {12'h108, 16'h0003, 16'h0003}) begin
         errors++;
         $display("FAIL las_result ws=%0d pc/ac/M11E got %h/%h/%h required 108/0003/0003",
                  ws, pc_o, ac_o, mem[12'h11E]);
      end
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL las_pending_writes got %0d required 0", sb_q.size());
         sb_q.delete();
      end
      wait_states = 0;
   endtask

   task automatic test_indirect();
      int edges;
      logic mid1, mid2;
      wait_states = 0;
      poke(12'h130, 16'h0140);
      poke(12'h140, 16'h1234);
      poke(12'h100, 16'hC130);
      poke(12'h102, 16'hE130);
      poke(12'h104, 16'hD130);
      poke(12'h106, 16'h6000);
      expect_write(12'h140, 16'h2468);
      start_cpu();
      edges = -1;
      mid1 = 1'b0;
      mid2 = 1'b0;
      for (int n = 1; n <= 100; n++) begin
         @(negedge clk);
         if (n == 5)  mid1 = (ac_o === 16'h1234);
         if (n == 10) mid2 = (ac_o === 16'h2468);
         if (halted) begin
            edges = n;
            break;
         end
      end
      checks++;
      if ({mid1, mid2} !== 2'b11) begin
         errors++;
         $display("FAIL ind_ac_timing loadi@5,addi@10 got %b required 11", {mid1, mid2});
      end
      checks++;
      if (edges !== 16) begin
         errors++;
         $display("FAIL ind_latency edges got %0d required 16", edges);
      end
      checks++;
      if ({ac_o, mem[12'h140]} !== {16'h2468, 16'h2468}) begin
         errors++;
         $display("FAIL ind_result ac/M140 got %h/%h required 2468/2468", ac_o, mem[12'h140]);
      end
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL ind_pending_writes got %0d required 0", sb_q.size());
         sb_q.delete();
      end
   endtask

   task automatic test_skip();
      int edges;
      logic [15:0] prog [0:12];
      prog = '{16'h1150, 16'h4000, 16'h6000, 16'h4002, 16'h2160, 16'h4001, 16'h2162,
               16'h4003, 16'h2164, 16'h3000, 16'h4001, 16'h2166, 16'h6000};
      poke(12'h150, 16'hFFFF);
      for (int i = 0; i < 13; i++) poke(12'h100 + 12'(2 * i), prog[i]);
      expect_write(12'h160, 16'hFFFF);
      expect_write(12'h162, 16'hFFFF);
      expect_write(12'h164, 16'hFFFF);
      start_cpu();
      run_to_halt(300, edges);
      checks++;
      if (edges < 0) begin
         errors++;
         $display("FAIL skip_timeout halted got 0 required 1");
      end
      checks++;
      if ({pc_o, ac_o} !== {12'h11A, 16'h0000}) begin
         errors++;
         $display("FAIL skip_result pc/ac got %h/%h required 11A/0000", pc_o, ac_o);
      end
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL skip_pending_writes got %0d required 0", sb_q.size());
         sb_q.delete();
      end
   endtask

   task automatic test_reset_mid_access();
      logic found;
      wait_states = 0;
      hold_ready  = 1'b0;
      poke(12'h150, 16'h5A5A);
      poke(12'h100, 16'h1150);
      start_cpu();
      found = 1'b0;
      for (int n = 0; n < 20; n++) begin
         if (mem_oe && mem_addr == 12'h150) begin
            found = 1'b1;
            hold_ready = 1'b1;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({found, mem_oe, mem_cs, mem_addr} !== {3'b111, 12'h150}) begin
         errors++;
         $display("FAIL opread_hold found,oe,cs,addr got %b,%b,%b,%h required 1,1,1,150",
                  found, mem_oe, mem_cs, mem_addr);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({mem_cs, mem_oe, mem_we, halted, pc_o, ac_o} !== {4'b0000, 12'h100, 16'h0000}) begin
         errors++;
         $display("FAIL rst_mid cs,oe,we,halted,pc,ac got %b%b%b%b,%h,%h required 0000,100,0000",
                  mem_cs, mem_oe, mem_we, halted, pc_o, ac_o);
      end
      hold_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({mem_cs, pc_o} !== {1'b0, 12'h100}) begin
         errors++;
         $display("FAIL rst_mid_idle cs,pc got %b,%h required 0,100", mem_cs, pc_o);
      end
   endtask

   initial begin
      test_reset();
      test_load_add_store(0, 13);
      test_load_add_store(3, 34);
      test_indirect();
      test_skip();
      test_reset_mid_access();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
